crc_frame_checker: RTL and testbench



---
 rtl/crc_chk_pkg.sv | 23 ++
 rtl/crc_frame_checker_crc16_byte_update.sv | 33 +++
 rtl/crc_frame_checker.sv | 176 +++++++++++++++++
 tb/tb_crc_frame_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/crc_chk_pkg.sv
// crc_chk_pkg
//   Shared constants and types for the CRC-16/XMODEM frame checker and the
//   reusable byte-wise CRC update function.
//   No ports (package).
package crc_chk_pkg;

    localparam logic [15:0] CRC_POLY      = 16'h1021;
    localparam logic [15:0] CRC_INIT      = 16'h0000;
    localparam int          PAYLOAD_BYTES = 14;
    localparam int          BLOCK_W       = 128;
    localparam int          CRC_W         = 16;
    localparam int          PAYLOAD_W     = BLOCK_W - CRC_W;
    localparam int          BYTE_IDX_W    = 4;
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [CRC_W-1:0]      ERR_COUNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } chk_state_e;

endpackage

// File: rtl/crc_frame_checker_crc16_byte_update.sv
// crc16_byte_update
//   Combinational next-CRC for CRC-16 (poly 0x1021), MSB-first, no
//   reflection. Processes one byte in eight unrolled bit steps. Shared with
//   the transmit-side CRC generator.
// Ports:
//   crc_in  [15:0]  current CRC
//   data    [7:0]   byte to fold in (bit 7 first)
//   crc_out [15:0]  CRC after the byte
module crc16_byte_update
    import crc_chk_pkg::*;
(
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       data,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] crc_work;

    always_comb begin
        // Pre-XOR the whole byte into the top; each step then only looks at the MSB.
        crc_work = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (crc_work[CRC_W-1]) begin
                crc_work = {crc_work[CRC_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_work = {crc_work[CRC_W-2:0], 1'b0};
            end
        end
    end

    assign crc_out = crc_work;

endmodule

// File: rtl/crc_frame_checker.sv
// crc_frame_checker
//   Byte-serial CRC-16/XMODEM checker for decrypted 128-bit blocks. The upper
//   112 bits are payload (byte 0 = [127:120]), the low 16 bits are the
//   received CRC. One payload byte is folded per cycle; the result is held
//   until the consumer accepts it.
//   Build option: define CRC_CHK_ERR_STATS_EN to enable the saturating
//   failed-block counter on err_count; otherwise err_count reads 0.
// Ports:
//   Clk, Rst            clock, async active-low reset
//   in_valid/in_ready   block handshake from the decryption stage
//   in_block [127:0]    payload [127:16], received CRC [15:0]
//   out_valid/out_ready result handshake to the consumer
//   out_payload [111:0] latched payload
//   out_crc_ok          computed CRC matches received CRC (valid with out_valid)
//   out_crc_calc [15:0] computed CRC
//   err_count [15:0]    saturating count of failed blocks
//
// state | meaning
// IDLE  | waiting for a block, in_ready=1
// CALC  | folding payload byte byte_idx into the CRC, one per cycle
// DONE  | result presented, waiting for out_ready
module crc_frame_checker
    import crc_chk_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BLOCK_W-1:0]   in_block,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_crc_ok,
    output logic [CRC_W-1:0]     out_crc_calc,
    output logic [CRC_W-1:0]     err_count
);

    chk_state_e              state_q,    state_d;
    logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [PAYLOAD_W-1:0]    payload_q,  payload_d;
    logic [CRC_W-1:0]        rx_crc_q,   rx_crc_d;
    logic [CRC_W-1:0]        crc_q,      crc_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    crc_ok_q,   crc_ok_d;

    logic [7:0]              cur_byte;
    logic [CRC_W-1:0]        crc_next;
    logic                    accept;
    logic                    handshake;

    // Constant part-selects per index keep the byte mux free of variable shifts.
    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (byte_idx_q == BYTE_IDX_W'(i)) begin
                cur_byte = payload_q[PAYLOAD_W-1-8*i -: 8];
            end
        end
    end

    crc16_byte_update u_crc16_byte_update (
        .crc_in  (crc_q),
        .data    (cur_byte),
        .crc_out (crc_next)
    );

    assign accept    = in_valid && in_ready_q;
    assign handshake = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        payload_d   = payload_q;
        rx_crc_d    = rx_crc_q;
        crc_d       = crc_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        crc_ok_d    = crc_ok_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    payload_d   = in_block[BLOCK_W-1:CRC_W];
                    rx_crc_d    = in_block[CRC_W-1:0];
                    crc_d       = CRC_INIT;
                    byte_idx_d  = '0;
                    crc_ok_d    = 1'b0;
                    in_ready_d  = 1'b0;
                    state_d     = CALC;
                end
            end
            CALC: begin
                if (byte_idx_q > LAST_BYTE_IDX) begin
                    // Unreachable index: drop the block rather than present garbage.
                    in_ready_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    crc_d      = crc_next;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == LAST_BYTE_IDX) begin
                        crc_ok_d    = (crc_next == rx_crc_q);
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            byte_idx_q  <= '0;
            payload_q   <= '0;
            rx_crc_q    <= '0;
            crc_q       <= CRC_INIT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            crc_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            payload_q   <= payload_d;
            rx_crc_q    <= rx_crc_d;
            crc_q       <= crc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            crc_ok_q    <= crc_ok_d;
        end
    end

`ifdef CRC_CHK_ERR_STATS_EN
    logic [CRC_W-1:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (handshake && !crc_ok_q && (err_count_q != ERR_COUNT_MAX)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
    assign err_count        = '0;
`endif

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_payload  = payload_q;
    assign out_crc_ok   = crc_ok_q;
    assign out_crc_calc = crc_q;

endmodule

// File: tb/tb_crc_frame_checker.sv
// tb_crc_frame_checker
//   Directed self-checking bench for crc_frame_checker. Expected CRCs are
//   hand-computed CRC-16/XMODEM values.
module tb_crc_frame_checker;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [111:0] out_payload;
    logic         out_crc_ok;
    logic [15:0]  out_crc_calc;
    logic [15:0]  err_count;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [15:0]  exp_err = 16'h0000;
    int           lat;

    localparam logic [111:0] PL_CHECK = 112'h0000000000_313233343536373839;
    localparam logic [111:0] PL_ONE   = 112'h01;
    localparam logic [111:0] PL_ZERO  = 112'h0;

    crc_frame_checker dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_block     (in_block),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_payload  (out_payload),
        .out_crc_ok   (out_crc_ok),
        .out_crc_calc (out_crc_calc),
        .err_count    (err_count)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one block, returns edges from accept to out_valid (41 = never).
    task automatic send_block(input string tag, input logic [127:0] blk, output int latency);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(negedge Clk);
            guard++;
        end
        check({tag, "_ready"}, 128'(in_ready), 128'(1'b1));
        in_block = blk;
        in_valid = 1'b1;
        @(posedge Clk);
        #1 in_valid = 1'b0;
        latency = 0;
        while (latency < 41) begin
            @(posedge Clk);
            latency++;
            #1;
            if (out_valid) break;
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge Clk);
        out_ready = 1'b1;
        @(posedge Clk);
        #1 out_ready = 1'b0;
        check({tag, "_valid_drop"}, 128'(out_valid), 128'(1'b0));
        check({tag, "_ready_back"}, 128'(in_ready), 128'(1'b1));
        check({tag, "_err_count"}, 128'(err_count), 128'(exp_err));
    endtask

    task automatic run_vector(input string tag, input logic [111:0] pl, input logic [15:0] rx,
                              input logic [15:0] exp_crc);
        logic exp_ok;
        exp_ok = (rx == exp_crc);
        send_block(tag, {pl, rx}, lat);
        check({tag, "_latency"}, 128'(lat), 128'(14));
        check({tag, "_crc_calc"}, 128'(out_crc_calc), 128'(exp_crc));
        check({tag, "_crc_ok"}, 128'(out_crc_ok), 128'(exp_ok));
        check({tag, "_payload"}, 128'(out_payload), 128'(pl));
`ifdef CRC_CHK_ERR_STATS_EN
        if (!exp_ok && exp_err != 16'hFFFF) exp_err = exp_err + 16'h1;
`endif
        handshake(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        Rst       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_block  = {PL_CHECK, 16'h31C3};

        // Reset held with in_valid asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("rst_in_ready", 128'(in_ready), 128'(1'b1));
            check("rst_out_valid", 128'(out_valid), 128'(1'b0));
            check("rst_payload", 128'(out_payload), 128'(0));
            check("rst_crc_ok", 128'(out_crc_ok), 128'(1'b0));
            check("rst_crc_calc", 128'(out_crc_calc), 128'(0));
            check("rst_err_count", 128'(err_count), 128'(0));
        end
        in_valid = 1'b0;
        Rst      = 1'b1;
        @(negedge Clk);
        check("post_rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("post_rst_out_valid", 128'(out_valid), 128'(1'b0));

        // Known check vector "123456789" behind five zero bytes
        run_vector("check_vec", PL_CHECK, 16'h31C3, 16'h31C3);
        // Single 0x01 in the last byte position: table entry 1
        run_vector("one_vec", PL_ONE, 16'h1021, 16'h1021);
        // Corrupted CRC field
        run_vector("corrupt", PL_CHECK, 16'h31C2, 16'h31C3);

        // Backpressure on an all-zero block, with ignored in_valid pulses
        send_block("bp", {PL_ZERO, 16'h0000}, lat);
        check("bp_latency", 128'(lat), 128'(14));
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            in_block = {PL_CHECK, 16'h1234};
            in_valid = (i % 2) == 0;
            check("bp_valid", 128'(out_valid), 128'(1'b1));
            check("bp_crc_calc", 128'(out_crc_calc), 128'(16'h0000));
            check("bp_crc_ok", 128'(out_crc_ok), 128'(1'b1));
            check("bp_in_ready", 128'(in_ready), 128'(1'b0));
            check("bp_payload", 128'(out_payload), 128'(PL_ZERO));
        end
        @(negedge Clk);
        in_valid = 1'b0;
        handshake("bp");
        repeat (3) @(negedge Clk);
        check("bp_no_ghost", 128'(out_valid), 128'(1'b0));
        check("bp_idle_ready", 128'(in_ready), 128'(1'b1));

        // Reset five edges after accept
        @(negedge Clk);
        in_block = {PL_ONE, 16'h1021};
        in_valid = 1'b1;
        @(posedge Clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge Clk);
        #1 Rst = 1'b0;
        #1;
        exp_err = 16'h0000;
        check("midrst_in_ready", 128'(in_ready), 128'(1'b1));
        check("midrst_out_valid", 128'(out_valid), 128'(1'b0));
        check("midrst_payload", 128'(out_payload), 128'(0));
        check("midrst_crc_ok", 128'(out_crc_ok), 128'(1'b0));
        check("midrst_crc_calc", 128'(out_crc_calc), 128'(0));
        check("midrst_err_count", 128'(err_count), 128'(0));
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        run_vector("after_rst", PL_CHECK, 16'h31C3, 16'h31C3);

`ifdef CRC_CHK_ERR_STATS_EN
        // Saturation from a preloaded count
        @(negedge Clk);
        force dut.err_count_q = 16'hFFFE;
        @(negedge Clk);
        release dut.err_count_q;
        exp_err = 16'hFFFE;
        check("sat_preload", 128'(err_count), 128'(16'hFFFE));
        for (int i = 0; i < 3; i++) begin
            run_vector("sat", PL_CHECK, 16'h0BAD, 16'h31C3);
            check("sat_value", 128'(err_count), 128'(16'hFFFF));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
